// File: rtl/fta_bus_pkg.sv
// Command bus types shared by bus masters and slaves: 128-bit request and response
// with a transaction id made of core, channel and a 4-bit tranid.
package fta_bus_pkg;

  typedef enum logic [3:0] {
    CMD_NONE  = 4'd0,
    CMD_LOAD  = 4'd1,
    CMD_STORE = 4'd2
  } fta_cmd_t;

  typedef struct packed {
    logic [5:0] core;
    logic [2:0] channel;
    logic [3:0] tranid;
  } fta_tranid_t;

  typedef struct packed {
    fta_tranid_t   tid;
    fta_cmd_t      cmd;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [15:0]   sel;
    logic [31:0]   adr;
    logic [127:0]  data1;
  } fta_cmd_request128_t;

  typedef struct packed {
    fta_tranid_t   tid;
    logic          ack;
    logic          rty;
    logic [127:0]  dat;
  } fta_cmd_response128_t;

endpackage

// File: rtl/rf80386_pkg.sv
// Core-side encodings for the rf386 bus interface: controller states and access sizes.
package rf80386_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StBackoff,
    StFinish
  } bus_state_e;

  localparam logic [1:0] SizeByte  = 2'd0;
  localparam logic [1:0] SizeWord  = 2'd1;
  localparam logic [1:0] SizeDword = 2'd2;

  // Size code 3 is treated as a dword.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SizeByte: return 3'd1;
      SizeWord: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rf386_lane_align.sv
// Combinational byte-lane shifter: maps access bytes k onto line lanes (off+k) mod 16
// for the selected part (low line or next line) in both store and load directions.
module rf386_lane_align (
  input  logic [3:0]   off_i,
  input  logic [2:0]   nbytes_i,
  input  logic         hi_part_i,
  input  logic [31:0]  st_dat_i,
  input  logic [127:0] ld_line_i,
  output logic [15:0]  sel_o,
  output logic [127:0] st_line_o,
  output logic [31:0]  ld_dat_o,
  output logic [3:0]   ld_mask_o
);

  logic [4:0] pos [4];
  logic [3:0] in_part;

  always_comb begin
    sel_o     = '0;
    st_line_o = '0;
    ld_dat_o  = '0;
    ld_mask_o = '0;
    for (int k = 0; k < 4; k++) begin
      pos[k]     = {1'b0, off_i} + 5'(k);
      // Bit 4 of the position says whether byte k spills into the next line.
      in_part[k] = (k < int'(nbytes_i)) && (pos[k][4] == hi_part_i);
      if (in_part[k]) begin
        sel_o[pos[k][3:0]]                      = 1'b1;
        st_line_o[{pos[k][3:0], 3'b000} +: 8]  = st_dat_i[k*8 +: 8];
        ld_dat_o[k*8 +: 8]                      = ld_line_i[{pos[k][3:0], 3'b000} +: 8];
        ld_mask_o[k]                            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf386_bus_iface.sv
// Core-to-bus access controller: splits unaligned accesses across 16-byte lines, issues
// tagged bus requests, handles retry back-off and response timeout.
module rf386_bus_iface
  import fta_bus_pkg::*;
  import rf80386_pkg::*;
#(
  parameter logic [5:0]  CORENO   = 6'd1,
  parameter logic [2:0]  CID      = 3'd1,
  parameter int unsigned RTY_WAIT = 16,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [1:0]           size_i,
  input  logic [31:0]          adr_i,
  input  logic [31:0]          dat_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          dat_o,
  output fta_cmd_request128_t  ftam_req,
  input  fta_cmd_response128_t ftam_resp
);

  localparam logic [7:0]  BoLast = 8'(RTY_WAIT - 1);
  localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);

  bus_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  nb_q, nb_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] st_dat_q, st_dat_d;
  logic        split_q, split_d;
  logic        part_q, part_d;
  logic [3:0]  tid_q, tid_d;
  logic [15:0] to_q, to_d;
  logic [7:0]  bo_q, bo_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] dat_q, dat_d;
  logic        err_q, err_d;

  logic [15:0]  sel;
  logic [127:0] st_line;
  logic [31:0]  ld_dat;
  logic [3:0]   ld_mask;
  logic [31:0]  acc_merged;
  logic [3:0]   next_tid;
  logic         match;
  logic         unused_resp;

  rf386_lane_align u_lane_align (
    .off_i     (adr_q[3:0]),
    .nbytes_i  (nb_q),
    .hi_part_i (part_q),
    .st_dat_i  (st_dat_q),
    .ld_line_i (ftam_resp.dat),
    .sel_o     (sel),
    .st_line_o (st_line),
    .ld_dat_o  (ld_dat),
    .ld_mask_o (ld_mask)
  );

  assign unused_resp = ^{ftam_resp.tid.core, ftam_resp.tid.channel};

  // Tranid 0 is reserved as "none outstanding", so the sequence runs 1..15.
  assign next_tid = (tid_q == 4'd15) ? 4'd1 : tid_q + 4'd1;
  assign match    = (ftam_resp.ack || ftam_resp.rty) && (ftam_resp.tid.tranid == tid_q);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      acc_merged[k*8 +: 8] = ld_mask[k] ? ld_dat[k*8 +: 8] : acc_q[k*8 +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    nb_d     = nb_q;
    adr_d    = adr_q;
    st_dat_d = st_dat_q;
    split_d  = split_q;
    part_d   = part_q;
    tid_d    = tid_q;
    to_d     = to_q;
    bo_d     = bo_q;
    acc_d    = acc_q;
    dat_d    = dat_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d     = we_i;
          nb_d     = size_bytes(size_i);
          adr_d    = adr_i;
          st_dat_d = dat_i;
          split_d  = ({1'b0, adr_i[3:0]} + {2'b00, size_bytes(size_i)}) > 5'd16;
          part_d   = 1'b0;
          acc_d    = '0;
          err_d    = 1'b0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        tid_d   = next_tid;
        to_d    = 16'd1;
        state_d = StWait;
      end
      StWait: begin
        to_d = to_q + 16'd1;
        if (match && ftam_resp.ack) begin
          if (!we_q) acc_d = acc_merged;
          if (split_q && !part_q) begin
            part_d  = 1'b1;
            state_d = StIssue;
          end else begin
            if (!we_q) dat_d = acc_merged;
            state_d = StFinish;
          end
        end else if (match) begin
          bo_d    = 8'd0;
          state_d = StBackoff;
        end else if (to_q >= ToLast) begin
          if (!we_q) dat_d = acc_q;
          err_d   = 1'b1;
          state_d = StFinish;
        end
      end
      StBackoff: begin
        bo_d = bo_q + 8'd1;
        if (bo_q >= BoLast) state_d = StIssue;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      nb_q     <= 3'd0;
      adr_q    <= '0;
      st_dat_q <= '0;
      split_q  <= 1'b0;
      part_q   <= 1'b0;
      tid_q    <= 4'd0;
      to_q     <= '0;
      bo_q     <= '0;
      acc_q    <= '0;
      dat_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      nb_q     <= nb_d;
      adr_q    <= adr_d;
      st_dat_q <= st_dat_d;
      split_q  <= split_d;
      part_q   <= part_d;
      tid_q    <= tid_d;
      to_q     <= to_d;
      bo_q     <= bo_d;
      acc_q    <= acc_d;
      dat_q    <= dat_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    ftam_req             = '0;
    ftam_req.tid.core    = CORENO;
    ftam_req.tid.channel = CID;
    if (state_q == StIssue) begin
      ftam_req.tid.tranid = next_tid;
      ftam_req.cmd        = we_q ? CMD_STORE : CMD_LOAD;
      ftam_req.cyc        = 1'b1;
      ftam_req.stb        = 1'b1;
      ftam_req.we         = we_q;
      ftam_req.sel        = sel;
      ftam_req.adr        = {adr_q[31:4] + 28'(part_q), 4'h0};
      ftam_req.data1      = we_q ? st_line : '0;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StFinish);
  assign err_o  = done_o && err_q;
  assign dat_o  = dat_q;

endmodule

// File: tb/tb_rf386_bus_iface.sv
// Bench for rf386_bus_iface: byte-addressed memory model plus a bus slave that answers
// with ack, retry, ack+retry, silence or unrelated noise.
module tb_rf386_bus_iface;
  import fta_bus_pkg::*;

  localparam int unsigned RtyWait = 16;
  localparam int unsigned Timeout = 1023;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_i, we_i;
  logic [1:0]           size_i;
  logic [31:0]          adr_i, dat_i;
  logic                 busy_o, done_o, err_o;
  logic [31:0]          dat_o;
  fta_cmd_request128_t  ftam_req;
  fta_cmd_response128_t ftam_resp;

  always #5 clk = ~clk;

  rf386_bus_iface #(
    .CORENO   (6'd1),
    .CID      (3'd1),
    .RTY_WAIT (RtyWait),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req_i),
    .we_i      (we_i),
    .size_i    (size_i),
    .adr_i     (adr_i),
    .dat_i     (dat_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .dat_o     (dat_o),
    .ftam_req  (ftam_req),
    .ftam_resp (ftam_resp)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] tid_m;
  logic [7:0] mem [logic [31:0]];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  function automatic logic [127:0] lane_mask(input logic [15:0] s);
    logic [127:0] m = '0;
    for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  function automatic logic [127:0] st_line(input logic [31:0] adr, input logic [31:0] dat,
                                           input int nb, input logic [31:0] ln);
    logic [127:0] v = '0;
    logic [31:0]  a;
    for (int k = 0; k < nb; k++) begin
      a = adr + 32'(k);
      if ({a[31:4], 4'h0} == ln) v[8*a[3:0] +: 8] = dat[8*k +: 8];
    end
    return v;
  endfunction

  // mode: 0 random responses, 1 ack after one cycle, 2 retry once then ack, 3 never answer
  task automatic run_access(input logic we, input logic [1:0] sz, input logic [31:0] adr,
                            input logic [31:0] dat, input int mode,
                            output int done_n, output logic [3:0] first_tid);
    int nb, nparts, part, resp_at, exp_done, exp_reissue, n_iss, rtys, kind, r;
    logic [31:0]  line [2];
    logic [15:0]  sel [2];
    logic [31:0]  exp_ld, a, cur_line;
    logic         exp_err;
    bit           finished;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    line[0] = {adr[31:4], 4'h0};
    line[1] = line[0] + 32'd16;
    sel[0] = '0;
    sel[1] = '0;
    exp_ld = '0;
    for (int k = 0; k < nb; k++) begin
      a = adr + 32'(k);
      if ({a[31:4], 4'h0} == line[0]) sel[0][a[3:0]] = 1'b1;
      else sel[1][a[3:0]] = 1'b1;
      exp_ld[8*k +: 8] = mem_rd(a);
      if (we) mem[a] = dat[8*k +: 8];
    end
    nparts = (sel[1] != '0) ? 2 : 1;
    part = 0; resp_at = -1; exp_done = -1; exp_reissue = -1; n_iss = 0; rtys = 0; kind = 0;
    exp_err = 1'b0; finished = 0; done_n = -1; first_tid = '0; cur_line = '0;
    we_i = we; size_i = sz; adr_i = adr; dat_i = dat; req_i = 1'b1;
    for (int n = 1; n <= 3000 && !finished; n++) begin
      @(negedge clk);
      req_i = 1'b0;
      ftam_resp = '0;
      check_eq("busy", busy_o, 1'b1);
      if (ftam_req.cyc) begin
        if (part >= nparts || exp_done >= 0 || resp_at >= 0) begin
          check_eq("extra_req", ftam_req.cyc, 1'b0);
        end else begin
          tid_m = (tid_m == 4'd15) ? 4'd1 : tid_m + 4'd1;
          if (n_iss == 0) first_tid = ftam_req.tid.tranid;
          n_iss++;
          check_eq("tranid", ftam_req.tid.tranid, tid_m);
          check_eq("adr", ftam_req.adr, line[part]);
          check_eq("sel", ftam_req.sel, sel[part]);
          check_eq("cmd", ftam_req.cmd, we ? CMD_STORE : CMD_LOAD);
          check_eq("stb_we", {ftam_req.stb, ftam_req.we}, {1'b1, we});
          check_eq("tid_src", {ftam_req.tid.core, ftam_req.tid.channel}, {6'd1, 3'd1});
          if (we) check_eq("st_data", ftam_req.data1 & lane_mask(sel[part]),
                           st_line(adr, dat, nb, line[part]));
          if (exp_reissue >= 0) check_eq("reissue_gap", n, exp_reissue);
          exp_reissue = -1;
          cur_line = line[part];
          case (mode)
            1: kind = 0;
            2: kind = (rtys == 0) ? 1 : 0;
            3: kind = 3;
            default: begin
              r = int'($urandom_range(0, 9));
              kind = (r < 2 && rtys < 2) ? 1 : (r == 2) ? 2 : 0;
            end
          endcase
          resp_at = n + ((mode == 0) ? int'($urandom_range(1, 4)) : 1);
          if (kind == 3) begin
            resp_at = -1;
            exp_done = n + int'(Timeout);
            exp_err = 1'b1;
          end
        end
      end else begin
        check_eq("idle_req", {ftam_req.cmd, ftam_req.sel, ftam_req.stb}, '0);
      end
      if (n == resp_at) begin
        ftam_resp.tid.core = 6'd1;
        ftam_resp.tid.channel = 3'd1;
        ftam_resp.tid.tranid = tid_m;
        ftam_resp.ack = (kind != 1);
        ftam_resp.rty = (kind == 1 || kind == 2);
        for (int i = 0; i < 16; i++) ftam_resp.dat[8*i +: 8] = mem_rd(cur_line + 32'(i));
        if (kind == 1) begin
          rtys++;
          exp_reissue = n + int'(RtyWait) + 1;
        end else begin
          part++;
          if (part == nparts) exp_done = n + 1;
        end
        resp_at = -1;
      end else if ($urandom_range(0, 3) == 0) begin
        // Noise: foreign tranid, or our tranid with neither ack nor rty.
        ftam_resp.dat = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 1) == 1) begin
          ftam_resp.tid.tranid = tid_m + 4'($urandom_range(1, 15));
          ftam_resp.ack = 1'b1;
          ftam_resp.rty = 1'($urandom_range(0, 1));
        end else begin
          ftam_resp.tid.tranid = tid_m;
        end
      end
      if (done_o || n == exp_done) begin
        check_eq("done_cycle", n, exp_done);
        check_eq("err", err_o, exp_err);
        check_eq("n_issue", n_iss, (exp_err ? part + 1 : nparts) + rtys);
        if (!we && !exp_err) check_eq("ld_data", dat_o, exp_ld);
        done_n = n;
        finished = 1;
      end
    end
    if (!finished) check_eq("done_seen", done_o, 1'b1);
    @(negedge clk);
    ftam_resp = '0;
    check_eq("idle_after", {busy_o, done_o}, 2'b00);
  endtask

  initial begin
    fta_cmd_request128_t exp_idle;
    int dn;
    logic [3:0] ft, stale;
    bit seen_done;
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = '0; adr_i = '0; dat_i = '0;
    ftam_resp = '0;
    tid_m = 4'd0;
    exp_idle = '0;
    exp_idle.tid.core = 6'd1;
    exp_idle.tid.channel = 3'd1;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {busy_o, done_o, err_o}, 3'b000);
    check_eq("rst_dat", dat_o, 32'd0);
    check_eq("rst_req", ftam_req == exp_idle, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Dword load at 0x1004, single line, 1-cycle ack
    run_access(1'b0, 2'd2, 32'h0000_1004, 32'd0, 1, dn, ft);
    check_eq("lat_037", dn + 1, 4);
    // Word store at 0x200F splits across two lines
    run_access(1'b1, 2'd1, 32'h0000_200F, 32'hCAFE_BEEF, 1, dn, ft);
    // Retry on first issue, then ack
    run_access(1'b0, 2'd2, 32'h0000_3008, 32'd0, 2, dn, ft);

    // Reset while waiting; a late ack must be ignored
    @(negedge clk);
    we_i = 1'b0; size_i = 2'd2; adr_i = 32'h0000_5000; req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    check_eq("rst_issue", ftam_req.cyc, 1'b1);
    stale = ftam_req.tid.tranid;
    @(negedge clk);
    check_eq("rst_wait_busy", busy_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_idle", {busy_o, done_o, err_o}, 3'b000);
    check_eq("rst_idle_req", ftam_req == exp_idle, 1'b1);
    ftam_resp.tid.core = 6'd1;
    ftam_resp.tid.channel = 3'd1;
    ftam_resp.tid.tranid = stale;
    ftam_resp.ack = 1'b1;
    seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      ftam_resp = '0;
      seen_done |= done_o;
    end
    check_eq("stale_done", seen_done, 1'b0);
    tid_m = 4'd0;

    // 16 byte loads: tranids 1..15 then wrap to 1
    for (int i = 0; i < 16; i++) begin
      run_access(1'b0, 2'd0, {$urandom} & 32'hFFFF_FFF0 | 32'(i), 32'd0, 1, dn, ft);
      check_eq("tid_seq", ft, (i == 15) ? 4'd1 : 4'(i + 1));
    end

    // Split dword with no response: timeout, second part never issued
    run_access(1'b0, 2'd2, 32'h0000_400E, 32'd0, 3, dn, ft);
    check_eq("timeout_lat", dn - 1, int'(Timeout));

    // Randomized accesses, offsets biased toward line ends
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      ra = {$urandom_range(0, 15), 4'h0, 8'h00, 8'($urandom), 4'h0};
      ra[3:0] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(12, 15))
                                            : 4'($urandom_range(0, 15));
      run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom, 0, dn, ft);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
